// File: rtl/dmem_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit: FSM states, access sizes,
// RISC-V load/store funct3 encodings and lane-mask helpers.
package lsu_types;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t;

  typedef enum logic [1:0] {
    BYTE   = 2'd0,
    HALF   = 2'd1,
    WORD   = 2'd2,
    DOUBLE = 2'd3
  } mem_size_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_funct3_t;

  typedef enum logic [2:0] {
    F3_SB = 3'b000,
    F3_SH = 3'b001,
    F3_SW = 3'b010,
    F3_SD = 3'b011
  } store_funct3_t;

  // Unsupported encodings collapse to a full-XLEN access; zero- vs sign-extension
  // is then irrelevant because nothing is extended.
  function automatic mem_size_t decode_size(input logic [2:0] funct3, input int unsigned xlen);
    if (funct3 == 3'b111)                     return (xlen == 64) ? DOUBLE : WORD;
    if (funct3[1:0] == 2'b11 && xlen == 32)   return WORD;
    return mem_size_t'(funct3[1:0]);
  endfunction

  function automatic logic [7:0] size_mask(input mem_size_t size);
    case (size)
      BYTE:    return 8'h01;
      HALF:    return 8'h03;
      WORD:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  // Offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input mem_size_t size);
    case (size)
      BYTE:    return 3'b000;
      HALF:    return 3'b001;
      WORD:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Cache-style data-memory request/response bus between the LSU (master)
// and the data memory (slave). Requests are held until dmem_resp.
interface dmem_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();
  localparam int BE_W = XLEN / 8;

  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [XLEN-1:0]   dmem_wdata;
  logic [BE_W-1:0]   dmem_byte_enable;
  logic [XLEN-1:0]   dmem_rdata;
  logic              dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/dmem_lsu_load_align.sv
// Load data alignment: shifts the addressed lane down, truncates to the access
// size and sign- or zero-extends to XLEN. Purely combinational.
module lsu_load_align
  import lsu_types::*;
#(
  parameter  int XLEN  = 32,
  localparam int BE_W  = XLEN / 8,
  localparam int OFF_W = $clog2(BE_W)
) (
  input  logic [XLEN-1:0]  rdata_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic [2:0]       funct3_i,
  output logic [XLEN-1:0]  result_o
);

  mem_size_t       size;
  logic [6:0]      nbits;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep;
  logic [XLEN-1:0] top;
  logic            sign;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    size     = decode_size(funct3_i, XLEN);
    nbits    = 7'd8 << size;
    shifted  = rdata_i >> {offset_i, 3'b000};
    keep     = ~({XLEN{1'b1}} << nbits);
    top      = keep & ~(keep >> 1);
    sign     = ~funct3_i[2] & (|(shifted & top));
    result_o = (shifted & keep) | ({XLEN{sign}} & ~keep);
  end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: registered, handshaked access to a cache-style data
// memory with pipeline stall. Optional macro DMEM_LSU_MISALIGN_TRAP_EN.
module dmem_lsu
  import lsu_types::*;
#(
  parameter  int XLEN   = 32,
  parameter  int ADDR_W = 32,
  localparam int BE_W   = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              stall,
  output logic              done,
  output logic [XLEN-1:0]   load_data,
  output logic              misaligned,
  dmem_lsu_if.master        dmem
);

  localparam int OFF_W = $clog2(BE_W);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  lsu_state_t        state_q;
  logic              read_q, write_q, done_q, mis_q, is_load_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q, load_data_q;
  logic [BE_W-1:0]   be_q;
  logic [OFF_W-1:0]  offset_q;
  logic [2:0]        funct3_q;

  logic              req, is_store, misaligned_req, trap;
  logic [OFF_W-1:0]  offset_d;
  mem_size_t         size_d;
  logic [ADDR_W-1:0] addr_d;
  logic [XLEN-1:0]   wdata_d;
  logic [BE_W-1:0]   be_d;
  logic [XLEN-1:0]   load_aligned;

  assign req            = req_valid & (req_load | req_store);
  assign is_store       = req_store;
  assign offset_d       = req_addr[OFF_W-1:0];
  assign size_d         = decode_size(req_funct3, XLEN);
  assign addr_d         = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign wdata_d        = req_wdata << {offset_d, 3'b000};
  // Lanes shifted past the top of the word are dropped.
  assign be_d           = BE_W'({8'h00, size_mask(size_d)} << offset_d);
  assign misaligned_req = |(3'(offset_d) & align_mask(size_d));
  assign trap           = TRAP_EN && misaligned_req;

  lsu_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i  (dmem.dmem_rdata),
    .offset_i (offset_q),
    .funct3_i (funct3_q),
    .result_o (load_aligned)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      done_q      <= 1'b0;
      mis_q       <= 1'b0;
      is_load_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      offset_q    <= '0;
      funct3_q    <= '0;
      load_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (req) begin
          addr_q    <= addr_d;
          wdata_q   <= wdata_d;
          be_q      <= be_d;
          offset_q  <= offset_d;
          funct3_q  <= req_funct3;
          is_load_q <= ~is_store;
          if (trap) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            mis_q       <= 1'b1;
            load_data_q <= '0;
          end else begin
            state_q <= ACCESS;
            read_q  <= ~is_store;
            write_q <= is_store;
          end
        end
        ACCESS: if (dmem.dmem_resp) begin
          read_q  <= 1'b0;
          write_q <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
          if (is_load_q) load_data_q <= load_aligned;
        end
        DONE: begin
          done_q  <= 1'b0;
          mis_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = ~rst & (((state_q == IDLE) & req) | (state_q == ACCESS));
  assign done       = done_q;
  assign misaligned = mis_q;
  assign load_data  = load_data_q;

  assign dmem.dmem_read        = read_q;
  assign dmem.dmem_write       = write_q;
  assign dmem.dmem_address     = addr_q;
  assign dmem.dmem_wdata       = wdata_q;
  assign dmem.dmem_byte_enable = be_q;

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Parametrised load/store unit for the MEM stage of the pipelined core. It replaces the single-cycle, combinational data-memory path with a registered, handshaked access to a cache-style memory (read/write held until resp). It generates byte enables, shifts store data, aligns and extends load data, and stalls the pipeline while an access is outstanding. It supports XLEN 32 or 64.

Parameters:
XLEN, 32, data width; legal values 32 or 64; sets dmem data width and load/store sizes.
ADDR_W, 32, byte-address width.
BE_W, XLEN/8, byte-enable width; derived, never overridden.

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
req_valid  in  1  MEM stage holds a memory instruction
req_load  in  1  instruction is a load
req_store  in  1  instruction is a store
req_funct3  in  3  RISC-V load/store funct3
req_addr  in  ADDR_W  effective byte address (ALU output)
req_wdata  in  XLEN  store source (rs2 value)
stall  out  1  hold all pipeline registers and PC
done  out  1  one-cycle pulse: access complete, load_data valid
load_data  out  XLEN  aligned, extended load result (registered)
misaligned  out  1  one-cycle pulse with done for a misaligned request
dmem_read  out  1  memory read request (registered)
dmem_write  out  1  memory write request (registered)
dmem_address  out  ADDR_W  request address, low log2(BE_W) bits zero
dmem_wdata  out  XLEN  store data shifted to byte lane
dmem_byte_enable  out  BE_W  lane mask
dmem_rdata  in  XLEN  read data, valid with dmem_resp
dmem_resp  in  1  memory completes current request

Behaviour:
- FSM states: IDLE, ACCESS, DONE.
- IDLE: a request is `req_valid & (req_load | req_store)`. On a request, the unit latches address, shifted data, enables, funct3 and offset, then moves to ACCESS. stall=1 combinationally in this cycle.
- If both req_load and req_store are set, the request is a store.
- ACCESS: dmem_read or dmem_write is 1, and all dmem_* outputs are held stable until dmem_resp. stall=1.
  - On dmem_resp, the unit registers load_data (loads only), drops read/write next cycle, and moves to DONE.
  - A resp in the first ACCESS cycle is legal.
- DONE: stall=0, done=1 for exactly one cycle, then IDLE. The same instruction must not be reissued, because the pipeline advances on this cycle.
- Minimum latency: request cycle → ACCESS → DONE, 3 cycles including the done cycle. Each additional memory wait cycle adds one.
- dmem_resp in IDLE or DONE is ignored.
- Sizes: funct3[1:0] 00 = byte, 01 = half, 10 = word, 11 = double (XLEN=64 only). funct3[2]=1 means zero-extend.
  - Unsupported sizes (011 or 11x when XLEN=32; 111 always) are treated as full-XLEN with zero-extension.
- Byte enable = size mask << offset, where offset = addr[log2(BE_W)-1:0]. dmem_wdata = req_wdata << (8*offset).
- Load extraction: rdata >> (8*offset), truncated to the access size, then sign- or zero-extended to XLEN.
- Misaligned means offset is not a multiple of the size. Behaviour for misaligned requests depends on the optional feature.
- Reset, including mid-ACCESS: state=IDLE, and all outputs are 0 in the cycle after rst: stall, done, load_data, misaligned, dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable. stall=0 while rst=1. Any outstanding memory response after reset is ignored.

Optional Feature:
DMEM_LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request skips ACCESS and goes IDLE→DONE, with no dmem_read/dmem_write. done=1, misaligned=1 and load_data=0 in DONE.
- Undefined: misaligned is tied to 0. The access is performed with mask << offset truncated to BE_W lanes, so upper bytes are dropped; this is the legacy behaviour.

Decomposition:
- Package lsu_types holds:
  - lsu_state_t enum (IDLE, ACCESS, DONE)
  - mem_size_t enum (BYTE, HALF, WORD, DOUBLE)
  - the size_mask function
  - load/store funct3 constants, extending the existing load_funct3_t/store_funct3_t with ld/lwu/sd
- Sub-module lsu_load_align: combinational rdata/offset/funct3 → extended XLEN result, instantiated once, feeding the load_data register.

Test Plan:
- XLEN=32, lw addr 0x100, resp in the first ACCESS cycle, rdata 0xDEADBEEF → stall high 2 cycles, done in cycle 3, load_data=0xDEADBEEF, address 0x100, be=4'b1111.
- XLEN=32, sb addr 0x203, wdata 0x000000A5 → dmem_address 0x200, be=4'b1000, dmem_wdata=0xA5000000, dmem_write held 4 cycles with resp delayed 3 cycles.
- lb then lbu at addr 0x002 with rdata 0x00800000 → load_data 0xFFFFFF80, then 0x00000080.
- With trap enabled, lh at 0x101 → no dmem_read, done=1 and misaligned=1 on cycle 2, load_data=0. Without trap, the same request → be=4'b0110 and an access is performed.
- rst asserted during ACCESS, then resp pulsed after rst → outputs 0 the next cycle, state IDLE, resp ignored, no done pulse.
- XLEN=64: sd at 0x8 gives be=8'hFF; lwu at 0xC with rdata 0x80000000_00000000 → load_data 0x0000000080000000.
